// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer, flush, and bubble masking.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 64,
  parameter int          SKID      = 1,
  parameter logic [31:0] NOP_INS   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ins,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_ins,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0]          ins;
    logic [31:0]          pc;
    logic [PAYLOAD_W-1:0] pay;
  } ent_t;

  ent_t in_e, m_q, m_d;
  logic mv_q, mv_d;
  logic sv;
  logic accept, pop;

  assign in_e   = '{ins: in_ins, pc: in_pc, pay: in_payload};
  assign accept = in_valid & in_ready;
  assign pop    = mv_q & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mv_q <= 1'b0;
      m_q  <= '0;
    end else begin
      mv_q <= mv_d;
      m_q  <= m_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      ent_t s_q, s_d;
      logic sv_q, sv_d;

      // Ready comes straight off the skid flop, so no combinational path from out_ready.
      assign in_ready = ~sv_q;
      assign sv       = sv_q;

      always_comb begin
        m_d  = m_q;
        mv_d = mv_q;
        s_d  = s_q;
        sv_d = sv_q;
        if (flush) begin
          mv_d = 1'b0;
          sv_d = 1'b0;
        end else begin
          if (pop) begin
            m_d  = s_q;
            mv_d = sv_q;
            sv_d = 1'b0;
          end
          if (accept) begin
            if (!mv_d) begin
              m_d  = in_e;
              mv_d = 1'b1;
            end else begin
              s_d  = in_e;
              sv_d = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sv_q <= 1'b0;
          s_q  <= '0;
        end else begin
          sv_q <= sv_d;
          s_q  <= s_d;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~mv_q | out_ready;
      assign sv       = 1'b0;

      always_comb begin
        m_d  = m_q;
        mv_d = mv_q;
        if (flush) begin
          mv_d = 1'b0;
        end else begin
          if (pop) mv_d = 1'b0;
          if (accept) begin
            m_d  = in_e;
            mv_d = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Invalid entries are masked so stale data never leaks downstream.
  assign out_valid   = mv_q;
  assign out_ins     = mv_q ? m_q.ins : NOP_INS;
  assign out_pc      = mv_q ? m_q.pc  : 32'h0;
  assign out_payload = mv_q ? m_q.pay : '0;
  assign occupancy   = {1'b0, mv_q} + {1'b0, sv};

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_q, bubble_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (mv_q && !out_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (!mv_q && bubble_q != 32'hFFFF_FFFF) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with identical stimulus and checks both against
// capacity-limited FIFO queue models (plus stall/bubble counts when perf counters are built in).
module tb_pipe_stage_reg;
  localparam int          PW  = 64;
  localparam logic [31:0] NOP = 32'hFFFF_0000;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [63:0] pay;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ins = '0, in_pc = '0;
  logic [PW-1:0] in_payload = '0;

  logic rdy1, vld1, rdy0, vld0;
  logic [31:0] ins1, pc1, ins0, pc0;
  logic [PW-1:0] pay1, pay0;
  logic [1:0] occ1, occ0;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] st1, bb1, st0, bb0;
`endif

  int checks = 0;
  int errors = 0;

  ent_t q1[$];
  ent_t q0[$];
  bit   r1_m, r0_m;
  longint st_m, bb_m;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(1), .NOP_INS(NOP)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_ins(in_ins), .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(vld1), .out_ready(out_ready),
    .out_ins(ins1), .out_pc(pc1), .out_payload(pay1),
    .occupancy(occ1)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt(st1), .bubble_cnt(bb1)
`endif
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(0), .NOP_INS(NOP)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_ins(in_ins), .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(vld0), .out_ready(out_ready),
    .out_ins(ins0), .out_pc(pc0), .out_payload(pay0),
    .occupancy(occ0)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt(st0), .bubble_cnt(bb0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Compare both DUTs against the queue models; also latches the model's pre-edge ready.
  task automatic check_outputs();
    ent_t h;
    r1_m = (q1.size() < 2);
    r0_m = (q0.size() == 0) || out_ready;
    chk("rdy1", 64'(rdy1), 64'(r1_m));
    chk("vld1", 64'(vld1), 64'(q1.size() > 0));
    chk("occ1", 64'(occ1), 64'(q1.size()));
    if (q1.size() > 0) begin
      h = q1[0];
      chk("ins1", 64'(ins1), 64'(h.ins));
      chk("pc1", 64'(pc1), 64'(h.pc));
      chk("pay1", pay1, h.pay);
    end else begin
      chk("ins1_nop", 64'(ins1), 64'(NOP));
      chk("pc1_zero", 64'(pc1), 64'h0);
      chk("pay1_zero", pay1, 64'h0);
    end
    chk("rdy0", 64'(rdy0), 64'(r0_m));
    chk("vld0", 64'(vld0), 64'(q0.size() > 0));
    chk("occ0", 64'(occ0), 64'(q0.size()));
    if (q0.size() > 0) begin
      h = q0[0];
      chk("ins0", 64'(ins0), 64'(h.ins));
      chk("pc0", 64'(pc0), 64'(h.pc));
      chk("pay0", pay0, h.pay);
    end else begin
      chk("ins0_nop", 64'(ins0), 64'(NOP));
      chk("pc0_zero", 64'(pc0), 64'h0);
      chk("pay0_zero", pay0, 64'h0);
    end
`ifdef PIPE_STAGE_REG_PERF_EN
    chk("stall_cnt", 64'(st1), 64'(st_m));
    chk("bubble_cnt", 64'(bb1), 64'(bb_m));
`endif
  endtask

  task automatic model_clear();
    q1.delete();
    q0.delete();
    st_m = 0;
    bb_m = 0;
  endtask

  // One clock: drive at negedge, check at negedge+1, advance models at posedge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [63:0] pay, input logic ordy);
    ent_t e;
    @(negedge clk);
    flush = fl; in_valid = iv; in_ins = ins; in_pc = pc; in_payload = pay; out_ready = ordy;
    #1;
    check_outputs();
    e.ins = ins; e.pc = pc; e.pay = pay;
    @(posedge clk);
    if (q1.size() > 0 && !ordy) st_m++;
    if (q1.size() == 0) bb_m++;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (iv && r1_m) q1.push_back(e);
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (iv && r0_m) q0.push_back(e);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(vld1), 64'h0);
    chk("rst_ins", 64'(ins1), 64'(NOP));
    chk("rst_occ", 64'(occ1), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h2001_0001 + 32'(i), 32'(i * 4), 64'h1000 + 64'(i), 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);

    // Back-pressure: A accepted, then stall while B and C are offered.
    step(1'b0, 1'b1, 32'hAAAA_0001, 32'h100, 64'hA, 1'b1);
    step(1'b0, 1'b1, 32'hBBBB_0002, 32'h104, 64'hB, 1'b0);
    step(1'b0, 1'b1, 32'hCCCC_0003, 32'h108, 64'hC, 1'b0);
    step(1'b0, 1'b1, 32'hCCCC_0003, 32'h108, 64'hC, 1'b0);
    chk("bp_occ2", 64'(occ1), 64'h2);
    chk("bp_hold_a", 64'(ins1), 64'hAAAA_0001);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'hCCCC_0003, 32'h108, 64'hC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);

    // Flush with two held entries and a same-cycle offer that must be discarded.
    step(1'b0, 1'b1, 32'h1111_0001, 32'h200, 64'h11, 1'b0);
    step(1'b0, 1'b1, 32'h2222_0002, 32'h204, 64'h22, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h208, 64'hDE, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);
    chk("fl_ins_nop", 64'(ins1), 64'(NOP));
    chk("fl_occ0", 64'(occ1), 64'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);

    // SKID=0 replace-in-place and combinational ready.
    step(1'b0, 1'b1, 32'h3333_0001, 32'h300, 64'h33, 1'b0);
    step(1'b0, 1'b1, 32'h4444_0002, 32'h304, 64'h44, 1'b1);
    step(1'b0, 1'b1, 32'h5555_0003, 32'h308, 64'h55, 1'b0);
    chk("s0_rdy_low", 64'(rdy0), 64'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b1);

    // Asynchronous reset between edges while the skid stage is full.
    step(1'b0, 1'b1, 32'h6666_0001, 32'h400, 64'h66, 1'b0);
    step(1'b0, 1'b1, 32'h7777_0002, 32'h404, 64'h77, 1'b0);
    step(1'b0, 1'b1, 32'h8888_0003, 32'h408, 64'h88, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("pre_arst_occ", 64'(occ1), 64'h2);
    reset = 1'b0;
    #1;
    chk("arst_vld", 64'(vld1), 64'h0);
    chk("arst_pay", pay1, 64'h0);
    chk("arst_occ", 64'(occ1), 64'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_rdy", 64'(rdy1), 64'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70, $urandom,
           $urandom & 32'hFFFF_FFFC, {$urandom, $urandom}, $urandom_range(0, 99) < 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
